// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and default port widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_ACC = 2'd1,
    DBG_RSP = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one DMEM between the CPU load/store port (default priority, combinational)
// and a req/ack debug port, with a starvation counter that forces debug service.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_cs,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              ack_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              dbg_grant;

  // Debug wins in IDLE when the CPU leaves the memory free or has starved it long enough.
  assign dbg_grant = dbg_req && (!cpu_cs || (starve_cnt == CNT_MAX));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ack_q      <= 1'b0;
      dbg_rdata  <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_grant) begin
            state      <= DBG_ACC;
            lat_we     <= dbg_we;
            lat_addr   <= dbg_addr;
            lat_wdata  <= dbg_wdata;
            starve_cnt <= '0;
          end else if (dbg_req) begin
            if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        DBG_ACC: begin
          if (!lat_we)
            dbg_rdata <= mem_rdata;
          ack_q <= 1'b1;
          state <= DBG_RSP;
        end
        DBG_RSP: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A reset landing on the response cycle must not leak an ack to the requester.
  assign dbg_ack = ack_q & ~reset;

  always_comb begin
    mem_cs    = cpu_cs;
    mem_r     = cpu_r;
    mem_w     = cpu_w;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    if (state == DBG_ACC) begin
      mem_cs    = 1'b1;
      mem_r     = ~lat_we;
      mem_w     = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      cpu_rdata = '0;
      cpu_stall = cpu_cs;
    end
    if (reset) begin
      mem_cs    = 1'b0;
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      cpu_stall = 1'b0;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (DMEM) between two requesters: the single-cycle CPU's load/store port and a debug/loader port, e.g. a UART program loader or a test-bench backdoor.
- Sits between the CPU and DMEM inside the top-level dataflow wrapper.
- The CPU has default priority and a zero-latency combinational path. Debug uses a req/ack handshake.
- A starvation counter guarantees debug service. It stalls the CPU for one cycle when needed.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, max IDLE cycles a pending dbg_req may be blocked by CPU accesses before debug is forced; 0 means debug is granted on the next cycle

Ports:
- clk_in  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_cs  in  1  CPU memory select
- cpu_r  in  1  CPU read enable
- cpu_w  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU address (ALU result)
- cpu_wdata  in  DATA_W  CPU store data (rt)
- cpu_rdata  out  DATA_W  load data to CPU
- cpu_stall  out  1  CPU must hold PC and suppress register/memory writeback this cycle
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  registered read data, valid while dbg_ack=1 and held until the next ack
- mem_cs  out  1  to DMEM
- mem_r  out  1  to DMEM
- mem_w  out  1  to DMEM
- mem_addr  out  ADDR_W  to DMEM
- mem_wdata  out  DATA_W  to DMEM
- mem_rdata  in  DATA_W  from DMEM; combinational read, write on clk_in edge

Behaviour:
- FSM states: IDLE, DBG_ACC, DBG_RSP.
- Reset behaviour (the reset cycle and the state that follows):
  - state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0, latched debug regs=0.
  - While reset=1: mem_cs, mem_r, mem_w and cpu_stall are forced to 0. No memory write occurs.
- IDLE:
  - mem_* are driven combinationally from cpu_*. cpu_rdata=mem_rdata, cpu_stall=0.
  - Transition to DBG_ACC if dbg_req=1 and (cpu_cs=0 or starve_cnt==STARVE_MAX).
  - On that transition: latch dbg_we, dbg_addr and dbg_wdata, and clear starve_cnt.
  - Otherwise, if dbg_req=1 and cpu_cs=1, increment starve_cnt, saturating at STARVE_MAX.
  - If dbg_req=0, clear starve_cnt.
- DBG_ACC (exactly 1 cycle):
  - mem_* are driven from the latched debug regs: mem_cs=1, mem_r=~we, mem_w=we.
  - cpu_stall=cpu_cs. cpu_rdata=0.
  - CPU signals never reach DMEM in this state.
  - At the clock edge: dbg_rdata<=mem_rdata on a read; on a write dbg_rdata is unchanged. Next state is DBG_RSP.
- DBG_RSP (exactly 1 cycle):
  - dbg_ack=1. The CPU path is combinational as in IDLE, with no stall.
  - dbg_req is ignored in this cycle. Next state is IDLE.
  - A requester that still holds dbg_req in IDLE is treated as issuing a new request.
- Latency:
  - Debug with an idle CPU: req seen at cycle N, access at N+1, ack at N+2.
  - Worst case under continuous CPU traffic: ack at N+STARVE_MAX+2.
  - CPU stall is at most 1 cycle per debug transaction.
- starve_cnt width is clog2(STARVE_MAX+1), with a minimum of 1 bit.
- Simultaneous CPU and debug access to the same address in IDLE: the CPU access completes first. The debug access then observes the CPU's write.
- Reset asserted in DBG_ACC: the latched write is not performed. No ack is issued; the requester must re-request.
- Reset asserted in DBG_RSP: the ack is dropped.
- Addresses pass through unmodified. Alignment is DMEM's concern.

Decomposition:
- Shared package/header dmem_arb_pkg holds:
  - state encodings: IDLE=2'd0, DBG_ACC=2'd1, DBG_RSP=2'd2
  - the default widths
- No sub-module. The starvation counter and FSM are small enough to stay in one module of about 150–200 lines.

Test Plan:
1. CPU only: cpu_cs=1, cpu_w=1, addr 0x10, data 0xDEADBEEF; next cycle cpu_r at 0x10 -> cpu_rdata=0xDEADBEEF, cpu_stall always 0, dbg_ack never asserted.
2. Debug read with idle CPU: preload 0x20=0x12345678; dbg_req/read 0x20 at cycle 0 -> mem_cs from debug at cycle 1, dbg_ack=1 and dbg_rdata=0x12345678 at cycle 2, cpu_stall=0 throughout.
3. Starvation: cpu_cs=1 every cycle, STARVE_MAX=4, dbg write 0x30=0xA5A5A5A5 at cycle 0 -> cpu_stall=1 only at cycle 5, dbg_ack at cycle 6, then CPU read 0x30 returns 0xA5A5A5A5.
4. Same-address race: CPU writes 0x40=0x1 in the same cycle as a debug read of 0x40 with STARVE_MAX=0 -> dbg_rdata=0x1.
5. Reset mid-op: reset asserted during DBG_ACC of a debug write 0x50=0xFFFF -> no write (0x50 keeps its old value), no dbg_ack, state IDLE, starve_cnt=0, dbg_rdata=0.
6. Held request: dbg_req kept at 1 through the ack -> second transaction starts in the IDLE cycle after DBG_RSP, with a second dbg_ack two cycles later.
